// File: rtl/pipe_flush_fifo.sv
// Elastic ready/valid FIFO with synchronous flush, occupancy and almost-full,
// drop-in multi-entry replacement for the front-end pipe skid buffer.
module pipe_flush_fifo #(
  parameter int unsigned DWIDTH       = 41,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [DWIDTH-1:0]          i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [DWIDTH-1:0]          o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              push, pop;

  assign o_ready     = (count_q != CW'(DEPTH));
  assign o_valid     = (count_q != '0);
  assign o_data      = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(DEPTH - AFULL_MARGIN));

  assign push = i_valid & o_ready;
  assign pop  = o_valid & i_ready;

  // Flush wins over everything; a concurrent pop still counts as consumed downstream.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push && !flush) mem_q[wr_ptr_q] <= i_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_pipe_flush_fifo.sv
// Directed bench for pipe_flush_fifo: reset, fill/drain, streaming, flush,
// full-with-pop and asynchronous reset mid-stream.
module tb_pipe_flush_fifo;

  localparam int unsigned DWIDTH = 41;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic [DWIDTH-1:0] i_data = '0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [DWIDTH-1:0] o_data;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic [CW-1:0]     count;
  logic              almost_full;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pipe_flush_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AFULL_MARGIN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hold(input logic [63:0] d);
    i_data  = DWIDTH'(d);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    // T1 reset
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t1_valid", 64'(o_valid), 64'd0);
    chk("t1_ready", 64'(o_ready), 64'd1);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_afull", 64'(almost_full), 64'd0);
    chk("t1_data",  64'(o_data), 64'd0);
    step();

    // T2 fill then drain
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_hold(64'(10 + k));
      chk("t2_count", 64'(count), 64'(k + 1));
      chk("t2_afull", 64'(almost_full), (k >= 2) ? 64'd1 : 64'd0);
      chk("t2_head",  64'(o_data), 64'hA);
      chk("t2_valid", 64'(o_valid), 64'd1);
    end
    chk("t2_ready_full", 64'(o_ready), 64'd0);
    push_hold(64'hE);
    chk("t2_no_accept", 64'(count), 64'd4);
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain", 64'(o_data), 64'(10 + k));
      step();
    end
    chk("t2_empty_cnt", 64'(count), 64'd0);
    chk("t2_empty_vld", 64'(o_valid), 64'd0);

    // T3 streaming
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_data = DWIDTH'(k);
      step();
      chk("t3_count", 64'(count), 64'd1);
      chk("t3_data",  64'(o_data), 64'(k));
    end
    i_valid = 1'b0;
    step();
    chk("t3_drained", 64'(count), 64'd0);

    // T4 flush
    i_ready = 1'b0;
    push_hold(64'd1);
    push_hold(64'd2);
    push_hold(64'd3);
    chk("t4_pre_cnt", 64'(count), 64'd3);
    flush   = 1'b1;
    i_valid = 1'b1;
    i_data  = DWIDTH'(9);
    i_ready = 1'b1;
    step();
    flush   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_valid", 64'(o_valid), 64'd0);
    chk("t4_ready", 64'(o_ready), 64'd1);
    chk("t4_afull", 64'(almost_full), 64'd0);
    push_hold(64'd5);
    chk("t4_next_data", 64'(o_data), 64'd5);
    chk("t4_next_cnt",  64'(count), 64'd1);
    i_ready = 1'b1;
    step();
    chk("t4_drained", 64'(count), 64'd0);

    // T5 full plus pop
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_hold(64'(16 + k));
    chk("t5_full", 64'(count), 64'd4);
    i_valid = 1'b1;
    i_data  = DWIDTH'(64'h99);
    i_ready = 1'b1;
    step();
    i_valid = 1'b0;
    chk("t5_count", 64'(count), 64'd3);
    for (int k = 1; k < 4; k++) begin
      chk("t5_order", 64'(o_data), 64'(16 + k));
      step();
    end
    chk("t5_empty", 64'(count), 64'd0);
    chk("t5_no_99", 64'(o_valid), 64'd0);

    // T6 asynchronous reset mid-stream
    i_ready = 1'b0;
    push_hold(64'h21);
    push_hold(64'h22);
    chk("t6_pre_cnt", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_valid", 64'(o_valid), 64'd0);
    chk("t6_ready", 64'(o_ready), 64'd1);
    chk("t6_data",  64'(o_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    push_hold(64'h33);
    chk("t6_head", 64'(o_data), 64'h33);
    chk("t6_cnt1", 64'(count), 64'd1);
    i_ready = 1'b1;
    step();
    chk("t6_drained", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
